ahb_slave_mem: RTL and testbench
================================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width.
- REGISTER_SELECT_BITS, 12, low address bits decoded as the byte offset inside the slave.
- MEMORY_DEPTH, 64, number of DATA_WIDTH words.
- WAIT_STATES, 2, wait cycles inserted per OKAY data phase (0..15).
REQ-002 Ports SHALL be:
- i_hclk  in  1  clock; all timing is on the rising edge.
- i_hreset  in  1  asynchronous active-low reset.
- i_hsel  in  1  slave select from the address decoder.
- i_haddr  in  ADDR_WIDTH  transfer address.
- i_htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- i_hwrite  in  1  1 = write.
- i_hsize  in  3  000 byte, 001 halfword, 010 word.
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- i_hready  in  1  muxed bus ready; high means the previous transfer completed.
- o_hrdata  out  DATA_WIDTH  read data.
- o_hreadyout  out  1  slave ready.
- o_hresp  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-003 An address phase SHALL be accepted at a rising edge when i_hsel=1, i_hready=1 and i_htrans[1]=1; the block SHALL then register haddr, hwrite and hsize.
REQ-004 IDLE or BUSY transfers, or transfers with i_hsel=0, SHALL get a zero-wait OKAY response (o_hreadyout=1, o_hresp=0) and SHALL cause no memory access.
REQ-005 An accepted transfer SHALL be flagged as an error if any of the following holds:
- offset = i_haddr[REGISTER_SELECT_BITS-1:0] is >= 4*MEMORY_DEPTH;
- i_hsize > 010;
- the address is misaligned (halfword with addr[0]=1, or word with addr[1:0]!=00).
REQ-006 The state machine SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-007 State transitions SHALL be:
- IDLE -> WAIT when an OKAY transfer is accepted and WAIT_STATES>0.
- IDLE -> ERR1 when an error transfer is accepted.
- IDLE -> IDLE otherwise.
- WAIT -> IDLE after WAIT_STATES cycles.
- ERR1 -> ERR2 -> IDLE.
REQ-008 In WAIT, o_hreadyout SHALL be 0 and o_hresp SHALL be 0; a 4-bit counter SHALL load WAIT_STATES-1 on entry and decrement each cycle, and the exit from WAIT is taken when the counter is 0.
REQ-009 The data phase SHALL complete in the cycle after WAIT exits (o_hreadyout=1, o_hresp=0), giving a total data-phase length of WAIT_STATES+1 cycles.
REQ-010 The ERROR response SHALL be two cycles:
- ERR1: o_hresp=1, o_hreadyout=0.
- ERR2: o_hresp=1, o_hreadyout=1.
- No memory write and no read update occur for an error transfer.
REQ-011 A write SHALL commit on the edge that completes its OKAY data phase, using registered i_hwdata byte lanes (little-endian):
- byte: lane addr[1:0];
- halfword: lanes {addr[1],0} and {addr[1],1};
- word: all four lanes.
REQ-012 For reads, o_hrdata SHALL present the full word mem[offset[..:2]] whenever the completing cycle has o_hreadyout=1; otherwise o_hrdata SHALL hold its last value.
REQ-013 A read whose address phase overlaps the completing data phase of a write to the same word SHALL return the newly written data.
REQ-014 A new address phase accepted in the same cycle a data phase completes SHALL be processed back-to-back with no idle cycle.
REQ-015 An address phase presented while o_hreadyout=0 SHALL be ignored until i_hready=1.

Reset
REQ-016 While i_hreset=0, the block SHALL asynchronously force:
- state to IDLE and the counter to 0;
- o_hreadyout=1, o_hresp=0, o_hrdata=0.
REQ-017 A reset asserted mid-transfer SHALL abort the transfer with no memory write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-018 When AHB_SLAVE_WAIT_EN is defined, wait states SHALL be inserted per REQ-008 and REQ-009.
REQ-019 When AHB_SLAVE_WAIT_EN is undefined, the WAIT state and the counter SHALL be omitted; every OKAY transfer SHALL complete with zero wait states, regardless of WAIT_STATES.

Verification
REQ-020 Word write 0xDEADBEEF to 0x004, then word read 0x004, WAIT_STATES=2 -> each data phase shows o_hreadyout low for 2 cycles then high; the read returns 0xDEADBEEF.
REQ-021 Byte write 0xAA to 0x006 over word 0x11223344 -> a word read of 0x004 returns 0x11AA3344.
REQ-022 Read at offset 0x100 (MEMORY_DEPTH=64) -> cycle 1: o_hresp=1, o_hreadyout=0; cycle 2: o_hresp=1, o_hreadyout=1; memory is unchanged.
REQ-023 Halfword write to 0x001 -> two-cycle ERROR response; a subsequent read of 0x000 returns the old value.
REQ-024 Back-to-back write 0x12345678 to 0x008 followed immediately by a read of 0x008, with the macro undefined -> zero waits; the read returns 0x12345678.
REQ-025 Assert i_hreset during WAIT of a write to 0x00C -> outputs reset immediately: o_hreadyout=1, o_hresp=0, o_hrdata=0; word 0x00C is unchanged.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-organised memory, with OKAY/ERROR responses.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_STATES wait cycles per OKAY data phase.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH           = 32,
    parameter int DATA_WIDTH           = 32,
    parameter int REGISTER_SELECT_BITS = 12,
    parameter int MEMORY_DEPTH         = 64,
    parameter int WAIT_STATES          = 2
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp
);

    localparam int          IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int          NB        = DATA_WIDTH / 8;
    localparam int unsigned MEM_BYTES = 4 * MEMORY_DEPTH;

`ifdef AHB_SLAVE_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;
    localparam bit ZERO_WAIT = 1'b1;
`endif

    state_t                          state;
    state_t                          state_n;
    logic                            dp_valid;
    logic                            write_q;
    logic [2:0]                      size_q;
    logic [IDX_W-1:0]                idx_q;
    logic [1:0]                      lo_q;
    logic [DATA_WIDTH-1:0]           mem [MEMORY_DEPTH];

    logic [REGISTER_SELECT_BITS-1:0] offset;
    logic                            accept;
    logic                            range_err;
    logic                            size_err;
    logic                            align_err;
    logic                            xfer_err;
    logic                            wr_commit;
    logic [NB-1:0]                   be;
    logic [DATA_WIDTH-1:0]           wr_word;
    logic [IDX_W-1:0]                rd_idx;
    logic                            rd_load;
    logic [DATA_WIDTH-1:0]           rd_word;
    logic                            unused;

`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0]                      wait_cnt;
    logic [3:0]                      wait_cnt_n;
    assign unused = ^{i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS], i_htrans[0]};
`else
    assign unused = ^{i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS], i_htrans[0],
                      4'(WAIT_STATES)};
`endif

    // Address decode and error classification of the current address phase.
    assign offset    = i_haddr[REGISTER_SELECT_BITS-1:0];
    assign range_err = (32'(offset) >= MEM_BYTES);
    assign size_err  = (i_hsize > 3'b010);
    assign align_err = ((i_hsize == 3'b001) && i_haddr[0]) ||
                       ((i_hsize == 3'b010) && (i_haddr[1:0] != 2'b00));
    assign xfer_err  = range_err || size_err || align_err;

    // New address phases are only taken while this slave is itself ready.
    assign accept = i_hsel && i_hready && i_htrans[1] && o_hreadyout;

    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        case (state)
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: o_hreadyout = 1'b0;
`endif
            ST_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
            end
            ST_ERR2: o_hresp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
`ifdef AHB_SLAVE_WAIT_EN
        wait_cnt_n = wait_cnt;
`endif
        case (state)
            // ERR2 completes the error response, so it may start the next transfer.
            ST_IDLE, ST_ERR2: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_n = ST_ERR1;
                    end
`ifdef AHB_SLAVE_WAIT_EN
                    else if (!ZERO_WAIT) begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = 4'(WAIT_STATES - 1);
                    end
`endif
                end
            end
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
`endif
            ST_ERR1: state_n = ST_ERR2;
            default: state_n = ST_IDLE;
        endcase
    end

    // An OKAY data phase completes in IDLE with o_hreadyout high.
    assign wr_commit = (state == ST_IDLE) && dp_valid && write_q;

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            case (size_q)
                3'b000:  be[b] = (2'(b) == lo_q);
                3'b001:  be[b] = (1'(b >> 1) == lo_q[1]);
                default: be[b] = 1'b1;
            endcase
        end
    end

    always_comb begin
        wr_word = mem[idx_q];
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                wr_word[8*b +: 8] = i_hwdata[8*b +: 8];
            end
        end
    end

    // Reads load o_hrdata on the edge entering their completing cycle.
    always_comb begin
        rd_idx  = offset[IDX_W+1:2];
        rd_load = accept && !xfer_err && !i_hwrite && ZERO_WAIT;
`ifdef AHB_SLAVE_WAIT_EN
        if (state == ST_WAIT) begin
            rd_idx  = idx_q;
            rd_load = (wait_cnt == 4'd0) && !write_q;
        end
`endif
    end

    // A read overlapping a completing write to the same word sees the new data.
    assign rd_word = (wr_commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];

    always_ff @(posedge i_hclk) begin
        if (wr_commit) begin
            mem[idx_q] <= wr_word;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 3'b000;
            idx_q    <= '0;
            lo_q     <= 2'b00;
            o_hrdata <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                write_q <= i_hwrite;
                size_q  <= i_hsize;
                idx_q   <= offset[IDX_W+1:2];
                lo_q    <= i_haddr[1:0];
            end
            if (o_hreadyout) begin
                dp_valid <= accept && !xfer_err;
            end
            if (rd_load) begin
                o_hrdata <= rd_word;
            end
        end
    end

`ifdef AHB_SLAVE_WAIT_EN
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            wait_cnt <= 4'd0;
        end else begin
            wait_cnt <= wait_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem; expected wait count follows
// whether AHB_SLAVE_WAIT_EN is defined for the build.
module tb_ahb_slave_mem;

    localparam int WS = 2;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = WS;
`else
    localparam int EXP_WAITS = 0;
`endif
    localparam int BOUND = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Single-slave bus: the muxed ready is this slave's own ready.
    assign hready = hreadyout;

    ahb_slave_mem #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .REGISTER_SELECT_BITS(12),
        .MEMORY_DEPTH(64),
        .WAIT_STATES(WS)
    ) dut (
        .i_hclk(clk),
        .i_hreset(rst_n),
        .i_hsel(hsel),
        .i_haddr(haddr),
        .i_htrans(htrans),
        .i_hwrite(hwrite),
        .i_hsize(hsize),
        .i_hwdata(hwdata),
        .i_hready(hready),
        .o_hrdata(hrdata),
        .o_hreadyout(hreadyout),
        .o_hresp(hresp)
    );

    // Single NONSEQ transfer; called and returns 1 time unit after a rising edge.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lows, output logic resp_first, output logic resp_last);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wdata;
        lows = 0;
        resp_first = hresp;
        while (hreadyout !== 1'b1 && lows < BOUND) begin
            lows++;
            @(posedge clk); #1;
        end
        rdata     = hrdata;
        resp_last = hresp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hreadyout !== 1'b1) begin
            errors++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout);
        end
        checks++;
        if (hresp !== 1'b0) begin
            errors++; $display("FAIL reset_hresp: got %b expected 0", hresp);
        end
        checks++;
        if (hrdata !== 32'h0) begin
            errors++; $display("FAIL reset_hrdata: got %h expected 00000000", hrdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h004, 1'b1, 3'b010, 32'hDEADBEEF, rd, lows, r0, r1);
        checks++;
        if (lows !== EXP_WAITS || r0 !== 1'b0 || r1 !== 1'b0) begin
            errors++; $display("FAIL word_wr_phase: waits %0d resp %b%b expected waits %0d resp 00",
                               lows, r0, r1, EXP_WAITS);
        end
        xfer(32'h004, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (lows !== EXP_WAITS || r1 !== 1'b0) begin
            errors++; $display("FAIL word_rd_phase: waits %0d resp %b expected waits %0d resp 0",
                               lows, r1, EXP_WAITS);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_rd_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h010, 1'b1, 3'b010, 32'hCAFEF00D, rd, lows, r0, r1);
        hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h010; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'hFFFFFFFF;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            errors++; $display("FAIL idle_resp: ready %b resp %b expected 1 0", hreadyout, hresp);
        end
        htrans = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            errors++; $display("FAIL busy_resp: ready %b resp %b expected 1 0", hreadyout, hresp);
        end
        hsel = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            errors++; $display("FAIL unsel_resp: ready %b resp %b expected 1 0", hreadyout, hresp);
        end
        htrans = 2'b00;
        xfer(32'h010, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL idle_no_access: got %h expected cafef00d", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h004, 1'b1, 3'b010, 32'h11223344, rd, lows, r0, r1);
        xfer(32'h006, 1'b1, 3'b000, 32'h00AA0000, rd, lows, r0, r1);
        checks++;
        if (lows !== EXP_WAITS || r1 !== 1'b0) begin
            errors++; $display("FAIL byte_wr_phase: waits %0d resp %b expected %0d 0", lows, r1, EXP_WAITS);
        end
        xfer(32'h004, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++; $display("FAIL byte_merge: got %h expected 11aa3344", rd);
        end
        xfer(32'h004, 1'b1, 3'b001, 32'hFFFF5566, rd, lows, r0, r1);
        xfer(32'h007, 1'b1, 3'b000, 32'h99FFFFFF, rd, lows, r0, r1);
        xfer(32'h004, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'h99AA5566) begin
            errors++; $display("FAIL half_byte_merge: got %h expected 99aa5566", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h000, 1'b1, 3'b010, 32'hA5A5A5A5, rd, lows, r0, r1);
        xfer(32'h000, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL err_pre_read: got %h expected a5a5a5a5", rd);
        end
        xfer(32'h100, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (lows !== 1 || r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL range_rd_err: low %0d resp %b%b expected 1 11", lows, r0, r1);
        end
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL err_hrdata_hold: got %h expected a5a5a5a5", rd);
        end
        xfer(32'h100, 1'b1, 3'b010, 32'h12121212, rd, lows, r0, r1);
        checks++;
        if (lows !== 1 || r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL range_wr_err: low %0d resp %b%b expected 1 11", lows, r0, r1);
        end
        xfer(32'h001, 1'b1, 3'b001, 32'hFFFFFFFF, rd, lows, r0, r1);
        checks++;
        if (lows !== 1 || r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL half_misalign_err: low %0d resp %b%b expected 1 11", lows, r0, r1);
        end
        xfer(32'h002, 1'b1, 3'b010, 32'hFFFFFFFF, rd, lows, r0, r1);
        checks++;
        if (lows !== 1 || r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL word_misalign_err: low %0d resp %b%b expected 1 11", lows, r0, r1);
        end
        xfer(32'h000, 1'b1, 3'b011, 32'hFFFFFFFF, rd, lows, r0, r1);
        checks++;
        if (lows !== 1 || r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL size_err: low %0d resp %b%b expected 1 11", lows, r0, r1);
        end
        xfer(32'h000, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'hA5A5A5A5 || r1 !== 1'b0) begin
            errors++; $display("FAIL err_mem_unchanged: got %h resp %b expected a5a5a5a5 0", rd, r1);
        end
        xfer(32'h0FC, 1'b1, 3'b010, 32'h0BADF00D, rd, lows, r0, r1);
        checks++;
        if (lows !== EXP_WAITS || r1 !== 1'b0) begin
            errors++; $display("FAIL top_word_wr: waits %0d resp %b expected %0d 0", lows, r1, EXP_WAITS);
        end
        xfer(32'hABCD_E0FC, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'h0BADF00D || r1 !== 1'b0) begin
            errors++; $display("FAIL top_word_rd: got %h resp %b expected 0badf00d 0", rd, r1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h008, 1'b1, 3'b010, 32'h00000000, rd, lows, r0, r1);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h008; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'h12345678;
        hwrite = 1'b0;
        lows = 0;
        while (hreadyout !== 1'b1 && lows < BOUND) begin
            lows++;
            @(posedge clk); #1;
        end
        checks++;
        if (lows !== EXP_WAITS || hresp !== 1'b0) begin
            errors++; $display("FAIL b2b_wr_phase: waits %0d resp %b expected %0d 0", lows, hresp, EXP_WAITS);
        end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        lows = 0;
        while (hreadyout !== 1'b1 && lows < BOUND) begin
            lows++;
            @(posedge clk); #1;
        end
        checks++;
        if (lows !== EXP_WAITS || hresp !== 1'b0) begin
            errors++; $display("FAIL b2b_rd_phase: waits %0d resp %b expected %0d 0", lows, hresp, EXP_WAITS);
        end
        checks++;
        if (hrdata !== 32'h12345678) begin
            errors++; $display("FAIL b2b_rd_data: got %h expected 12345678", hrdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] rd;
        int          lows;
        logic        r0, r1;
        xfer(32'h00C, 1'b1, 3'b010, 32'h0C0C0C0C, rd, lows, r0, r1);
        xfer(32'h00C, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'h0C0C0C0C) begin
            errors++; $display("FAIL rst_pre_read: got %h expected 0c0c0c0c", rd);
        end
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h00C; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBADBAD00;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resp: ready %b resp %b expected 1 0", hreadyout, hresp);
        end
        checks++;
        if (hrdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_hrdata: got %h expected 00000000", hrdata);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hwdata = 32'h0;
        @(posedge clk); #1;
        xfer(32'h00C, 1'b0, 3'b010, 32'h0, rd, lows, r0, r1);
        checks++;
        if (rd !== 32'h0C0C0C0C) begin
            errors++; $display("FAIL rst_no_write: got %h expected 0c0c0c0c", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_idle_busy();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
